mac_beam_sched: RTL and testbench
=================================

// Module: mac_beam_sched
// PURPOSE
//  Time-multiplexes one mac_ants instance across NBEAM beams. Accepts one RE of ANT
//  antenna samples per handshake and replays it NBEAM times, each with that beam's
//  code word from a double-buffered table. Emits a beam tag aligned to the MAC output
//  so downstream can demux the per-beam sums. Sits between the antenna-combine
//  front end and mac_ants.
// PARAMETERS
//  ANT      32  antennas per RE
//  IW       32  sample/code-word width, {I[31:16],Q[15:0]}
//  NBEAM    16  beams per RE, >=1; BW=max(1,$clog2(NBEAM)) is a localparam
//  MAC_LAT  11  mac_ants input->output latency, >=1
// PORTS
//  i_clk        in   1        clock
//  i_reset      in   1        synchronous reset, active-high
//  i_ants_data  in   ANT*IW   RE antenna samples
//  i_valid      in   1        RE valid
//  i_sop        in   1        first RE of symbol, qualified by i_valid
//  i_eop        in   1        last RE of symbol, qualified by i_valid
//  o_ready      out  1        RE accepted when i_valid && o_ready
//  i_cw_wr      in   1        code-word write strobe, always to inactive bank
//  i_cw_addr    in   BW       beam index written
//  i_cw_data    in   ANT*IW   code word for that beam
//  i_cw_swap    in   1        pulse: request bank swap
//  o_ants_data  out  ANT*IW   to mac_ants i_ants_data
//  o_code_word  out  ANT*IW   to mac_ants i_code_word
//  o_rvalid     out  1        to mac_ants i_rvalid
//  o_sop        out  1        to mac_ants i_sop
//  o_eop        out  1        to mac_ants i_eop
//  o_tag_valid  out  1        beam tag valid, aligned with mac_ants o_tvalid
//  o_tag_beam   out  BW       beam index of current MAC output
//  o_active_bank out 1        bank used by the RE being issued
//  o_seq_err    out  1        sticky: sop seen while symbol open
// BEHAVIOUR
//  - FSM IDLE/ISSUE, beam counter bcnt.
//  - o_ready = (IDLE) || (ISSUE && bcnt==NBEAM-1).
//  - Accept at cycle t: latch data/sop/eop, enter ISSUE, bcnt=0.
//  - Cycles t+1..t+NBEAM: o_rvalid=1, o_ants_data=latched RE,
//    o_code_word=table[active][bcnt], bcnt increments by 1.
//  - o_sop/o_eop = latched sop/eop, repeated on every beam of that RE.
//  - Outputs are registered.
//  - Accept on last beam: issue continues with bcnt=0 and no bubble, so throughput is
//    1 RE per NBEAM cycles.
//  - Otherwise on last beam: go to IDLE; o_rvalid, o_sop, o_eop are 0 the next cycle.
//  - NBEAM=1: o_ready is constant 1 and ISSUE lasts one cycle per RE.
//  - in_symbol flag: set on accept with i_sop; cleared after the last beam of an
//    accepted i_eop RE is issued.
//  - sop+eop on the same RE is a one-RE symbol and leaves in_symbol cleared.
//  - Accept with i_sop while in_symbol=1: set o_seq_err (sticky until reset) and treat
//    the RE as a new symbol.
//  - i_eop with in_symbol=0 and no i_sop: pass through, no error.
//  - Swap: i_cw_swap sets swap_pend.
//  - Active bank toggles, and swap_pend clears, in the first cycle with swap_pend=1 and
//    in_symbol=0.
//  - A sop RE accepted in that same cycle uses the new bank.
//  - Bank is latched per RE at accept, so a swap never changes a bank mid-RE.
//  - Swap request while swap_pend=1: absorbed (one toggle only).
//  - Table writes: i_cw_wr writes table[~active][i_cw_addr].
//  - Writes with i_cw_addr>=NBEAM are ignored.
//  - A write in the same cycle as the toggle goes to the bank that is inactive before
//    the toggle.
//  - The table is RAM and is not reset.
//  - Tag pipe: MAC_LAT-deep shift of {o_rvalid,bcnt_issued}.
//  - Beam b issued at cycle c produces o_tag_valid=1, o_tag_beam=b at cycle c+MAC_LAT.
//  - Reset: IDLE, bcnt=0, in_symbol=0, swap_pend=0, active=0, o_seq_err=0.
//  - Reset: tag pipe cleared; all outputs 0 except o_ready=1.
//  - Reset mid-ISSUE aborts the remaining beams.
//  - Arithmetic: bcnt wraps NBEAM-1 -> 0, never reaching NBEAM.
// TESTING
//  - Single RE sop+eop, NBEAM=16 -> 16 consecutive o_rvalid cycles, bcnt 0..15.
//  - Each o_code_word equals that beam's table[0] entry; o_ready low on cycles t+1..t+15.
//  - o_tag_valid for beams 0..15 at t+12..t+27.
//  - Back-to-back 4-RE symbol, i_valid held 1 -> 64 contiguous o_rvalid cycles.
//  - o_sop on cycles 1-16 only, o_eop on cycles 49-64 only.
//  - Load bank1 mid-symbol and pulse swap at RE 2 -> REs 2-3 still use bank0.
//  - Next sop RE uses bank1 and o_active_bank=1.
//  - Write at addr=NBEAM -> table unchanged.
//  - Two sops without eop -> o_seq_err=1 and stays 1.
//  - Second RE issued normally from beam 0.
//  - Reset asserted at beam 7 -> next cycle o_rvalid=0, o_ready=1, o_tag_valid=0.
//  - After reset, o_active_bank=0.

Source files
------------

// File: rtl/mac_beam_sched.sv
// mac_beam_sched: replays each accepted RE of ANT antenna samples once per beam,
// pairing it with that beam's code word from a double-buffered table, and
// produces a beam tag that lines up with the mac_ants output.
//
//   state   | meaning
//   IDLE    | no RE held, ready for a new one
//   ISSUE   | replaying the held RE, one beam per cycle (bcnt = beam on outputs)
module mac_beam_sched #(
  parameter int ANT     = 32,
  parameter int IW      = 32,
  parameter int NBEAM   = 16,
  parameter int MAC_LAT = 11
) (
  input  logic                                   i_clk,
  input  logic                                   i_reset,
  input  logic [ANT*IW-1:0]                      i_ants_data,
  input  logic                                   i_valid,
  input  logic                                   i_sop,
  input  logic                                   i_eop,
  output logic                                   o_ready,
  input  logic                                   i_cw_wr,
  input  logic [((NBEAM > 1) ? $clog2(NBEAM) : 1)-1:0] i_cw_addr,
  input  logic [ANT*IW-1:0]                      i_cw_data,
  input  logic                                   i_cw_swap,
  output logic [ANT*IW-1:0]                      o_ants_data,
  output logic [ANT*IW-1:0]                      o_code_word,
  output logic                                   o_rvalid,
  output logic                                   o_sop,
  output logic                                   o_eop,
  output logic                                   o_tag_valid,
  output logic [((NBEAM > 1) ? $clog2(NBEAM) : 1)-1:0] o_tag_beam,
  output logic                                   o_active_bank,
  output logic                                   o_seq_err
);

  localparam int BW = (NBEAM > 1) ? $clog2(NBEAM) : 1;
  localparam int DW = ANT * IW;
  localparam logic [BW-1:0] LAST_BEAM = BW'(NBEAM - 1);

  typedef enum logic {S_IDLE = 1'b0, S_ISSUE = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [BW-1:0]   bcnt, bcnt_nxt;
  logic            lat_sop, lat_eop;
  logic            in_symbol, swap_pend, active;
  logic            last_beam, accept, in_sym_eff, do_swap, active_nxt, wr_bank;
  logic            rv_nxt, sop_src, eop_src, bank_src;
  logic [DW-1:0]   cw_mem [2][NBEAM];
  logic [MAC_LAT-1:0] tag_v;
  logic [BW-1:0]   tag_b [MAC_LAT];

  assign last_beam = (state == S_ISSUE) && (bcnt == LAST_BEAM);
  assign accept    = i_valid && o_ready;
  // The symbol counts as closed during the last beam of its eop RE, so a swap
  // and a following sop RE can both land in that cycle without a bubble.
  assign in_sym_eff = in_symbol && !(last_beam && lat_eop);
  assign do_swap    = swap_pend && !in_sym_eff;
  assign active_nxt = active ^ do_swap;
  assign wr_bank    = ~active;

  // state register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= S_IDLE;
      bcnt  <= '0;
    end else begin
      state <= state_nxt;
      bcnt  <= bcnt_nxt;
    end
  end

  // next-state: accept starts beam 0, last beam either chains or returns to idle
  always_comb begin
    state_nxt = state;
    bcnt_nxt  = bcnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = S_ISSUE;
          bcnt_nxt  = '0;
        end
      end
      S_ISSUE: begin
        if (last_beam) begin
          bcnt_nxt = '0;
          if (!accept) state_nxt = S_IDLE;
        end else begin
          bcnt_nxt = bcnt + BW'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        bcnt_nxt  = '0;
      end
    endcase
  end

  // outputs of the FSM: ready plus the source selection for the next issued beam
  always_comb begin
    o_ready  = (state == S_IDLE) || last_beam;
    rv_nxt   = (state_nxt == S_ISSUE);
    sop_src  = accept ? i_sop : lat_sop;
    eop_src  = accept ? i_eop : lat_eop;
    bank_src = accept ? active_nxt : o_active_bank;
  end

  // symbol tracking, bank swap handshake and sequence error
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      in_symbol <= 1'b0;
      swap_pend <= 1'b0;
      active    <= 1'b0;
      o_seq_err <= 1'b0;
      lat_sop   <= 1'b0;
      lat_eop   <= 1'b0;
    end else begin
      in_symbol <= (accept && i_sop) ? 1'b1 : in_sym_eff;
      swap_pend <= do_swap ? 1'b0 : (swap_pend | i_cw_swap);
      active    <= active_nxt;
      if (accept && i_sop && in_sym_eff) o_seq_err <= 1'b1;
      if (accept) begin
        lat_sop <= i_sop;
        lat_eop <= i_eop;
      end
    end
  end

  // registered issue outputs; the RE and its bank are held for all its beams
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_rvalid      <= 1'b0;
      o_sop         <= 1'b0;
      o_eop         <= 1'b0;
      o_ants_data   <= '0;
      o_code_word   <= '0;
      o_active_bank <= 1'b0;
    end else begin
      o_rvalid <= rv_nxt;
      o_sop    <= rv_nxt && sop_src;
      o_eop    <= rv_nxt && eop_src;
      if (accept) begin
        o_ants_data   <= i_ants_data;
        o_active_bank <= active_nxt;
      end
      if (rv_nxt) o_code_word <= cw_mem[bank_src][bcnt_nxt];
    end
  end

  // code-word table: writes always target the bank not currently active
  always_ff @(posedge i_clk) begin
    if (i_cw_wr && (int'(i_cw_addr) < NBEAM)) cw_mem[wr_bank][i_cw_addr] <= i_cw_data;
  end

  // beam tag delay line matching the mac_ants latency
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < MAC_LAT; i++) begin
        tag_v[i] <= 1'b0;
        tag_b[i] <= '0;
      end
    end else begin
      tag_v[0] <= o_rvalid;
      tag_b[0] <= o_rvalid ? bcnt : '0;
      for (int i = 1; i < MAC_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_b[i] <= tag_b[i-1];
      end
    end
  end

  assign o_tag_valid = tag_v[MAC_LAT-1];
  assign o_tag_beam  = tag_b[MAC_LAT-1];

endmodule

// File: tb/tb_mac_beam_sched.sv
// Directed bench for mac_beam_sched: default build plus a small NBEAM=5 build
// for the out-of-range table write and non-power-of-two beam count.
module tb_mac_beam_sched;

  localparam int ANT = 32, IW = 32, NBEAM = 16, MAC_LAT = 11, BW = 4;
  localparam int DW = ANT * IW;
  localparam int S_ANT = 2, S_NB = 5, S_LAT = 2, S_BW = 3;
  localparam int S_DW = S_ANT * IW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [DW-1:0] ants, cw_data, o_ants, o_cw;
  logic valid, sop, eop, ready, cw_wr, cw_swap;
  logic [BW-1:0] cw_addr, tag_beam;
  logic rvalid, osop, oeop, tag_valid, active_bank, seq_err;

  logic [S_DW-1:0] s_ants, s_cw_data, s_o_ants, s_o_cw;
  logic s_valid, s_sop, s_eop, s_ready, s_cw_wr, s_cw_swap;
  logic [S_BW-1:0] s_cw_addr, s_tag_beam;
  logic s_rvalid, s_osop, s_oeop, s_tag_valid, s_active_bank, s_seq_err;

  mac_beam_sched #(.ANT(ANT), .IW(IW), .NBEAM(NBEAM), .MAC_LAT(MAC_LAT)) u_dut (
    .i_clk(clk), .i_reset(rst), .i_ants_data(ants), .i_valid(valid), .i_sop(sop),
    .i_eop(eop), .o_ready(ready), .i_cw_wr(cw_wr), .i_cw_addr(cw_addr),
    .i_cw_data(cw_data), .i_cw_swap(cw_swap), .o_ants_data(o_ants),
    .o_code_word(o_cw), .o_rvalid(rvalid), .o_sop(osop), .o_eop(oeop),
    .o_tag_valid(tag_valid), .o_tag_beam(tag_beam), .o_active_bank(active_bank),
    .o_seq_err(seq_err));

  mac_beam_sched #(.ANT(S_ANT), .IW(IW), .NBEAM(S_NB), .MAC_LAT(S_LAT)) u_small (
    .i_clk(clk), .i_reset(rst), .i_ants_data(s_ants), .i_valid(s_valid), .i_sop(s_sop),
    .i_eop(s_eop), .o_ready(s_ready), .i_cw_wr(s_cw_wr), .i_cw_addr(s_cw_addr),
    .i_cw_data(s_cw_data), .i_cw_swap(s_cw_swap), .o_ants_data(s_o_ants),
    .o_code_word(s_o_cw), .o_rvalid(s_rvalid), .o_sop(s_osop), .o_eop(s_oeop),
    .o_tag_valid(s_tag_valid), .o_tag_beam(s_tag_beam), .o_active_bank(s_active_bank),
    .o_seq_err(s_seq_err));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    int lane;
    checks++;
    if (got !== exp) begin
      lane = 0;
      for (int i = ANT - 1; i >= 0; i--)
        if (got[i*IW +: IW] !== exp[i*IW +: IW]) lane = i;
      errors++;
      $display("FAIL %s lane %0d got %h exp %h", tag, lane, got[lane*IW +: IW], exp[lane*IW +: IW]);
    end
  endtask

  function automatic logic [DW-1:0] pat(input logic [7:0] t, input int b);
    logic [DW-1:0] r;
    for (int i = 0; i < ANT; i++) r[i*IW +: IW] = {t, 8'(i), 8'(b), 8'hA5};
    return r;
  endfunction

  function automatic logic [S_DW-1:0] spat(input logic [7:0] t, input int b);
    logic [DW-1:0] r;
    r = pat(t, b);
    return r[S_DW-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_cw(input int a, input logic [DW-1:0] d);
    cw_wr = 1'b1; cw_addr = BW'(a); cw_data = d;
    tick();
    cw_wr = 1'b0;
  endtask

  task automatic swap_pulse();
    cw_swap = 1'b1;
    tick();
    cw_swap = 1'b0;
    tick();
    tick();
  endtask

  task automatic send_re(input logic [DW-1:0] d, input logic s, input logic e);
    bit done;
    done = 1'b0;
    ants = d; valid = 1'b1; sop = s; eop = e;
    for (int n = 0; n < 40 && !done; n++) begin
      if (ready) done = 1'b1;
      tick();
    end
    valid = 1'b0; sop = 1'b0; eop = 1'b0;
    check("send_accept", DW'(done), DW'(1));
  endtask

  // Checks the 16 beams of one RE; returns at its last-beam cycle.
  task automatic check_re(input string tag, input logic [DW-1:0] d, input logic [7:0] bt,
                          input logic s, input logic e, input logic bank);
    for (int k = 0; k < NBEAM; k++) begin
      check($sformatf("%s_b%0d_rv", tag, k), DW'(rvalid), DW'(1));
      check($sformatf("%s_b%0d_cw", tag, k), o_cw, pat(bt, k));
      check($sformatf("%s_b%0d_ants", tag, k), o_ants, d);
      check($sformatf("%s_b%0d_sop", tag, k), DW'(osop), DW'(s));
      check($sformatf("%s_b%0d_eop", tag, k), DW'(oeop), DW'(e));
      check($sformatf("%s_b%0d_bank", tag, k), DW'(active_bank), DW'(bank));
      check($sformatf("%s_b%0d_rdy", tag, k), DW'(ready), DW'(k == NBEAM - 1));
      if (k < NBEAM - 1) tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, r, b;
    rst = 1'b1;
    ants = '0; valid = 0; sop = 0; eop = 0; cw_wr = 0; cw_addr = '0; cw_data = '0; cw_swap = 0;
    s_ants = '0; s_valid = 0; s_sop = 0; s_eop = 0; s_cw_wr = 0; s_cw_addr = '0;
    s_cw_data = '0; s_cw_swap = 0;
    tick();
    tick();

    // reset state
    check("rst_ready", DW'(ready), DW'(1));
    check("rst_rvalid", DW'(rvalid), DW'(0));
    check("rst_tagv", DW'(tag_valid), DW'(0));
    check("rst_bank", DW'(active_bank), DW'(0));
    check("rst_seqerr", DW'(seq_err), DW'(0));
    check("rst_cw", o_cw, '0);
    check("rst_sop", DW'(osop), DW'(0));
    check("rst_s_ready", DW'(s_ready), DW'(1));
    rst = 1'b0;
    tick();

    // fill bank0: swap to bank1 active, write bank0, swap back
    swap_pulse();
    for (int k = 0; k < NBEAM; k++) wr_cw(k, pat(8'hB0, k));
    swap_pulse();

    // single sop+eop RE with tag alignment
    ants = pat(8'hD1, 100); valid = 1'b1; sop = 1'b1; eop = 1'b1;
    check("t1_ready_idle", DW'(ready), DW'(1));
    tick();
    valid = 1'b0; sop = 1'b0; eop = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      check($sformatf("t1_c%0d_rv", n), DW'(rvalid), DW'(n <= 16));
      check($sformatf("t1_c%0d_rdy", n), DW'(ready), DW'(n >= 16));
      if (n <= 16) begin
        check($sformatf("t1_c%0d_cw", n), o_cw, pat(8'hB0, n - 1));
        check($sformatf("t1_c%0d_ants", n), o_ants, pat(8'hD1, 100));
        check($sformatf("t1_c%0d_sopeop", n), DW'({osop, oeop}), DW'(2'b11));
        check($sformatf("t1_c%0d_bank", n), DW'(active_bank), DW'(0));
      end
      check($sformatf("t1_c%0d_tagv", n), DW'(tag_valid), DW'(n >= 12 && n <= 27));
      if (n >= 12 && n <= 27)
        check($sformatf("t1_c%0d_tagb", n), DW'(tag_beam), DW'(n - 12));
      tick();
    end

    // 4-RE symbol back-to-back, bank1 loaded during RE1, swap pulsed during RE2,
    // followed immediately by a one-RE symbol that must use bank1
    for (int n = 0; n <= 82; n++) begin
      idx = (n + 15) / 16;
      valid   = (idx <= 4);
      ants    = pat(8'(8'hD0 + idx), 100);
      sop     = (idx <= 4) && (idx == 0 || idx == 4);
      eop     = (idx <= 4) && (idx == 3 || idx == 4);
      cw_wr   = (n >= 17 && n <= 32);
      cw_addr = BW'(n - 17);
      cw_data = pat(8'hC1, n - 17);
      cw_swap = (n == 33);
      check($sformatf("t2_c%0d_rdy", n), DW'(ready), DW'((n % 16 == 0) || n > 80));
      if (n >= 1) begin
        r = (n - 1) / 16;
        b = (n - 1) % 16;
        check($sformatf("t2_c%0d_rv", n), DW'(rvalid), DW'(n <= 80));
        if (n <= 80) begin
          check($sformatf("t2_c%0d_ants", n), o_ants, pat(8'(8'hD0 + r), 100));
          check($sformatf("t2_c%0d_cw", n), o_cw, (r < 4) ? pat(8'hB0, b) : pat(8'hC1, b));
          check($sformatf("t2_c%0d_sop", n), DW'(osop), DW'(n <= 16 || n >= 65));
          check($sformatf("t2_c%0d_eop", n), DW'(oeop), DW'(n >= 49));
          check($sformatf("t2_c%0d_bank", n), DW'(active_bank), DW'(r == 4));
        end
      end
      tick();
    end
    valid = 0; sop = 0; eop = 0; cw_wr = 0; cw_swap = 0;
    check("t2_seqerr_clear", DW'(seq_err), DW'(0));

    // eop without an open symbol passes through without error
    send_re(pat(8'hE1, 100), 1'b0, 1'b1);
    check_re("t3", pat(8'hE1, 100), 8'hC1, 1'b0, 1'b1, 1'b1);
    tick();
    check("t3_seqerr", DW'(seq_err), DW'(0));

    // two sops without eop: sticky error, second RE still issued from beam 0
    send_re(pat(8'hA1, 100), 1'b1, 1'b0);
    check("t4_seqerr_a", DW'(seq_err), DW'(0));
    check_re("t4a", pat(8'hA1, 100), 8'hC1, 1'b1, 1'b0, 1'b1);
    send_re(pat(8'hA2, 100), 1'b1, 1'b0);
    check("t4_seqerr_b", DW'(seq_err), DW'(1));
    check_re("t4b", pat(8'hA2, 100), 8'hC1, 1'b1, 1'b0, 1'b1);
    send_re(pat(8'hA3, 100), 1'b0, 1'b1);
    check_re("t4c", pat(8'hA3, 100), 8'hC1, 1'b0, 1'b1, 1'b1);
    tick(); tick(); tick();
    check("t4_seqerr_sticky", DW'(seq_err), DW'(1));

    // reset at beam 7 aborts the RE
    send_re(pat(8'hF1, 100), 1'b1, 1'b1);
    for (int k = 0; k < 7; k++) tick();
    check("t5_beam7_cw", o_cw, pat(8'hC1, 7));
    rst = 1'b1;
    tick();
    check("t5_rv", DW'(rvalid), DW'(0));
    check("t5_rdy", DW'(ready), DW'(1));
    check("t5_tagv", DW'(tag_valid), DW'(0));
    check("t5_bank", DW'(active_bank), DW'(0));
    check("t5_seqerr", DW'(seq_err), DW'(0));
    rst = 1'b0;
    tick();
    tick();
    check("t5_rv_after", DW'(rvalid), DW'(0));
    check("t5_rdy_after", DW'(ready), DW'(1));

    // small build: out-of-range writes ignored, 5-beam wrap, MAC_LAT=2 tags
    for (int k = 0; k < S_NB; k++) begin
      s_cw_wr = 1'b1; s_cw_addr = S_BW'(k); s_cw_data = spat(8'h51, k);
      tick();
    end
    s_cw_addr = 3'd5; s_cw_data = spat(8'hEE, 5);
    tick();
    s_cw_addr = 3'd7; s_cw_data = spat(8'hEE, 7);
    tick();
    s_cw_wr = 1'b0;
    s_cw_swap = 1'b1;
    tick();
    s_cw_swap = 1'b0;
    tick(); tick();
    s_ants = spat(8'h77, 0); s_valid = 1'b1; s_sop = 1'b1; s_eop = 1'b1;
    check("s_ready_idle", DW'(s_ready), DW'(1));
    tick();
    s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      check($sformatf("s_c%0d_rv", n), DW'(s_rvalid), DW'(n <= 5));
      check($sformatf("s_c%0d_rdy", n), DW'(s_ready), DW'(n >= 5));
      if (n <= 5) begin
        check($sformatf("s_c%0d_cw", n), DW'(s_o_cw), DW'(spat(8'h51, n - 1)));
        check($sformatf("s_c%0d_bank", n), DW'(s_active_bank), DW'(1));
      end
      check($sformatf("s_c%0d_tagv", n), DW'(s_tag_valid), DW'(n >= 3 && n <= 7));
      if (n >= 3 && n <= 7)
        check($sformatf("s_c%0d_tagb", n), DW'(s_tag_beam), DW'(n - 3));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
